// File: rtl/dmp_update_arbiter_if.sv
// Request bus between the DMP stream threads and the accumulator update arbiter.
interface dmp_update_arbiter_if #(
    parameter int unsigned NUM_HW_THREADS = 8
);
    localparam int unsigned DATA_W = 32;

    logic [NUM_HW_THREADS-1:0]             req_valid;
    logic [NUM_HW_THREADS-1:0][DATA_W-1:0] req_dest;
    logic [NUM_HW_THREADS-1:0][DATA_W-1:0] req_val;
    logic [NUM_HW_THREADS-1:0]             req_ready;
    logic [NUM_HW_THREADS-1:0]             thread_done;

    modport master (output req_valid, req_dest, req_val, thread_done, input req_ready);
    modport slave  (input req_valid, req_dest, req_val, thread_done, output req_ready);
endinterface

// File: rtl/dmp_update_arbiter.sv
// Round-robin arbiter feeding a 2-stage read-modify-write into the pagerank accumulator.
// Optional perf counters are enabled with `define DMP_ARB_PERF_EN.
module dmp_update_arbiter #(
    parameter int unsigned NUM_HW_THREADS = 8,
    parameter int unsigned NODES_IN_GRAPH = 32,
    parameter int unsigned ADDR_W         = 5
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                nextIteration,
    dmp_update_arbiter_if.slave req,
    output logic                mem_rd_en,
    output logic [ADDR_W-1:0]   mem_rd_addr,
    input  logic [31:0]         mem_rd_data,
    output logic                mem_wr_en,
    output logic [ADDR_W-1:0]   mem_wr_addr,
    output logic [31:0]         mem_wr_data,
    output logic                dest_err,
    output logic                DMP_operation_complete
`ifdef DMP_ARB_PERF_EN
    ,
    output logic [31:0]                    perf_updates,
    output logic [31:0]                    perf_fwd,
    output logic [NUM_HW_THREADS-1:0][15:0] perf_wait
`endif
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = (NUM_HW_THREADS > 1) ? $clog2(NUM_HW_THREADS) : 1;
    localparam logic [DATA_W-1:0] NODES_LIM = DATA_W'(NODES_IN_GRAPH);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    state_t                    state_q, state_d;
    logic                      start;
    logic [IDX_W-1:0]          ptr_q;
    logic [NUM_HW_THREADS-1:0] done_q;
    logic                      err_q;

    logic                      s1_valid_q;
    logic [ADDR_W-1:0]         s1_addr_q;
    logic [DATA_W-1:0]         s1_val_q;
    logic                      lw_valid_q;
    logic [ADDR_W-1:0]         lw_addr_q;
    logic [DATA_W-1:0]         lw_data_q;

    logic [NUM_HW_THREADS-1:0] grant;
    logic [IDX_W-1:0]          grant_idx;
    logic [IDX_W-1:0]          idx;
    logic                      grant_found;
    logic [DATA_W-1:0]         gnt_dest;
    logic [DATA_W-1:0]         gnt_val;
    logic                      accept_ok;
    logic                      accept_bad;
    logic                      forward;
    logic [DATA_W-1:0]         wr_sum;

    // First requester at or above the pointer, wrapping around.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        idx         = '0;
        if (state_q == ST_RUN) begin
            for (int unsigned k = 0; k < NUM_HW_THREADS; k++) begin
                idx = IDX_W'(DATA_W'(ptr_q) + k);
                if (!grant_found && req.req_valid[idx]) begin
                    grant_found = 1'b1;
                    grant_idx   = idx;
                end
            end
        end
        if (grant_found) grant[grant_idx] = 1'b1;
    end

    assign gnt_dest   = req.req_dest[grant_idx];
    assign gnt_val    = req.req_val[grant_idx];
    assign accept_ok  = grant_found && (gnt_dest < NODES_LIM);
    assign accept_bad = grant_found && (gnt_dest >= NODES_LIM);

    // The write issued last cycle is not yet visible through the read port.
    assign forward = lw_valid_q && (lw_addr_q == s1_addr_q);
    assign wr_sum  = (forward ? lw_data_q : mem_rd_data) + s1_val_q;

    assign req.req_ready          = reset_n ? grant : '0;
    assign mem_rd_en              = reset_n && accept_ok;
    assign mem_rd_addr            = (reset_n && accept_ok) ? gnt_dest[ADDR_W-1:0] : '0;
    assign mem_wr_en              = reset_n && s1_valid_q;
    assign mem_wr_addr            = reset_n ? s1_addr_q : '0;
    assign mem_wr_data            = reset_n ? wr_sum : '0;
    assign dest_err               = reset_n && err_q;
    assign DMP_operation_complete = reset_n && (state_q == ST_DONE);

    // Iteration sequencing.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (nextIteration) begin
                    state_d = ST_RUN;
                    start   = 1'b1;
                end
            end
            ST_RUN:   if ((&done_q) && !(|req.req_valid)) state_d = ST_DRAIN;
            ST_DRAIN: if (!s1_valid_q) state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            done_q     <= '0;
            err_q      <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            s1_val_q   <= '0;
            lw_valid_q <= 1'b0;
            lw_addr_q  <= '0;
            lw_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            s1_valid_q <= accept_ok;
            lw_valid_q <= s1_valid_q;
            lw_addr_q  <= s1_addr_q;
            lw_data_q  <= wr_sum;
            if (grant_found) ptr_q <= grant_idx + IDX_W'(1);
            if (accept_ok) begin
                s1_addr_q <= gnt_dest[ADDR_W-1:0];
                s1_val_q  <= gnt_val;
            end
            if (start) begin
                done_q <= '0;
                err_q  <= 1'b0;
            end else begin
                if (state_q == ST_RUN) done_q <= done_q | req.thread_done;
                if (accept_bad) err_q <= 1'b1;
            end
        end
    end

`ifdef DMP_ARB_PERF_EN
    // Per-iteration activity counters; frozen outside RUN/DRAIN activity.
    always_ff @(posedge clock) begin
        if (!reset_n || start) begin
            perf_updates <= '0;
            perf_fwd     <= '0;
            perf_wait    <= '0;
        end else begin
            if (accept_ok) perf_updates <= perf_updates + 32'd1;
            if (s1_valid_q && forward) perf_fwd <= perf_fwd + 32'd1;
            if (state_q == ST_RUN) begin
                for (int unsigned i = 0; i < NUM_HW_THREADS; i++) begin
                    if (req.req_valid[i] && !grant[i] && (perf_wait[i] != 16'hFFFF))
                        perf_wait[i] <= perf_wait[i] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmp_update_arbiter.sv
// Randomized bench for dmp_update_arbiter against a running-sum accumulator model.
module tb_dmp_update_arbiter;
    localparam int N     = 8;
    localparam int NODES = 32;
    localparam int AW    = 5;

    logic          clock;
    logic          reset_n;
    logic          nextIteration;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [31:0]   mem_rd_data;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic [31:0]   mem_wr_data;
    logic          dest_err;
    logic          DMP_operation_complete;

    dmp_update_arbiter_if #(.NUM_HW_THREADS(N)) intf ();

    dmp_update_arbiter #(.NUM_HW_THREADS(N), .NODES_IN_GRAPH(NODES), .ADDR_W(AW)) dut (
        .clock(clock), .reset_n(reset_n), .nextIteration(nextIteration), .req(intf),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .dest_err(dest_err), .DMP_operation_complete(DMP_operation_complete)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Accumulator memory: read data one cycle later, same-cycle read returns old data.
    logic [31:0] mem [NODES];
    logic        tb_clr, tb_ld;
    logic [AW-1:0] ld_a;
    logic [31:0] ld_d;
    always @(posedge clock) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
        if (tb_clr) for (int i = 0; i < NODES; i++) mem[i] <= 32'd0;
        else if (tb_ld) mem[ld_a] <= ld_d;
        else if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    end

    int n_checks = 0;
    int n_err    = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase, RR pointer, done set, and the expected accumulator contents.
    int          m_state = 0;  // 0 idle, 1 run, 2 drain, 3 done
    int          m_ptr   = 0;
    logic [N-1:0] m_done = '0;
    logic        m_err   = 1'b0;
    logic        m_pv    = 1'b0;
    int          m_pa    = 0;
    logic [31:0] m_pval  = 0;
    logic [31:0] m_acc [NODES];
    int          g;
    logic        exp_wr, exp_rd;
    logic [31:0] exp_wdata;
    logic [N-1:0] exp_ready, hs_last, last_ready;
    logic        last_rd_en, last_wr_en;
    int          glog[$];
    logic [31:0] wlog[$];
    int          walog[$];

    always @(negedge clock) begin
        g = -1;
        exp_ready = '0;
        if (reset_n && m_state == 1)
            for (int k = 0; k < N; k++)
                if (g < 0 && intf.req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        if (g >= 0) exp_ready[g] = 1'b1;
        exp_rd    = (g >= 0) && (intf.req_dest[g] < NODES);
        exp_wr    = reset_n && m_pv;
        exp_wdata = m_acc[m_pa] + m_pval;

        chk("req_ready", 32'(intf.req_ready), 32'(exp_ready));
        chk("mem_rd_en", 32'(mem_rd_en), 32'(exp_rd));
        if (exp_rd) chk("mem_rd_addr", 32'(mem_rd_addr), intf.req_dest[g]);
        chk("mem_wr_en", 32'(mem_wr_en), 32'(exp_wr));
        if (exp_wr) begin
            chk("mem_wr_addr", 32'(mem_wr_addr), 32'(m_pa));
            chk("mem_wr_data", mem_wr_data, exp_wdata);
        end
        chk("dest_err", 32'(dest_err), 32'(reset_n && m_err));
        chk("complete", 32'(DMP_operation_complete), 32'(reset_n && m_state == 3));

        for (int i = 0; i < N; i++) if (intf.req_ready[i]) glog.push_back(i);
        if (mem_wr_en) begin wlog.push_back(mem_wr_data); walog.push_back(int'(mem_wr_addr)); end
        hs_last    = intf.req_valid & intf.req_ready;
        last_ready = intf.req_ready;
        last_rd_en = mem_rd_en;
        last_wr_en = mem_wr_en;

        if (!reset_n) begin
            m_state = 0; m_ptr = 0; m_done = '0; m_err = 1'b0; m_pv = 1'b0;
        end else begin
            if (tb_clr) for (int i = 0; i < NODES; i++) m_acc[i] = 32'd0;
            else if (tb_ld) m_acc[ld_a] = ld_d;
            else if (exp_wr) m_acc[m_pa] = exp_wdata;
            m_pv = 1'b0;
            if (g >= 0) begin
                m_ptr = (g + 1) % N;
                if (intf.req_dest[g] < NODES) begin
                    m_pv = 1'b1; m_pa = int'(intf.req_dest[g]); m_pval = intf.req_val[g];
                end else m_err = 1'b1;
            end
            case (m_state)
                0, 3: if (nextIteration) begin m_state = 1; m_done = '0; m_err = 1'b0; end
                1: begin
                    if ((&m_done) && intf.req_valid == '0) m_state = 2;
                    m_done = m_done | intf.thread_done;
                end
                2: if (!exp_wr) m_state = 3;
                default: m_state = 0;
            endcase
        end
    end

    task automatic cyc();
        @(posedge clock); #1;
    endtask
    task automatic step();
        cyc();
        intf.req_valid = intf.req_valid & ~hs_last;
    endtask
    task automatic req_set(input int t, input logic [31:0] d, input logic [31:0] v);
        intf.req_valid[t] = 1'b1; intf.req_dest[t] = d; intf.req_val[t] = v;
    endtask
    task automatic pulse_next();
        nextIteration = 1'b1; cyc(); nextIteration = 1'b0;
    endtask
    task automatic wait_idle(input int bound);
        int c = 0;
        while (intf.req_valid != '0 && c < bound) begin step(); c++; end
        chk("wait_idle", 32'(intf.req_valid), 32'd0);
    endtask
    task automatic wait_complete(input int bound);
        int c = 0;
        while (DMP_operation_complete !== 1'b1 && c < bound) begin cyc(); c++; end
        chk("wait_complete", 32'(DMP_operation_complete), 32'd1);
    endtask
    function automatic int qg(input int i);
        return (i < glog.size()) ? glog[i] : -1;
    endfunction
    function automatic logic [31:0] qw(input int i);
        return (i < wlog.size()) ? wlog[i] : 32'hDEAD_BEEF;
    endfunction

    int bg, bw, cnt;

    initial begin
        reset_n = 1'b0; nextIteration = 1'b0; tb_clr = 1'b0; tb_ld = 1'b0; ld_a = '0; ld_d = '0;
        intf.req_valid = '0; intf.req_dest = '0; intf.req_val = '0; intf.thread_done = '0;
        cyc(); tb_clr = 1'b1; cyc(); tb_clr = 1'b0; cyc();
        chk("reset_complete", 32'(DMP_operation_complete), 32'd0);
        chk("reset_wr_en", 32'(mem_wr_en), 32'd0);
        chk("reset_err", 32'(dest_err), 32'd0);
        reset_n = 1'b1; cyc();
        pulse_next();

        // Three threads hitting dest 3 in the same cycle.
        bg = glog.size(); bw = wlog.size();
        for (int t = 0; t < 3; t++) req_set(t, 32'd3, 32'h0001_0000);
        wait_idle(10); step(); step();
        for (int i = 0; i < 3; i++) chk("t1_grant_order", 32'(qg(bg + i)), 32'(i));
        chk("t1_wr1", qw(bw), 32'h0001_0000);
        chk("t1_wr2", qw(bw + 1), 32'h0002_0000);
        chk("t1_wr3", qw(bw + 2), 32'h0003_0000);
        chk("t1_mem3", mem[3], 32'h0003_0000);

        // Move pointer to 5, then all threads hold valid for 16 cycles.
        req_set(4, 32'd0, 32'd1); wait_idle(10);
        bg = glog.size();
        intf.req_valid = '1;
        for (int c = 0; c < 16; c++) begin
            for (int t = 0; t < N; t++) begin
                intf.req_dest[t] = 32'($urandom_range(0, 7)); intf.req_val[t] = $urandom;
            end
            cyc();
        end
        intf.req_valid = '0; step(); step();
        for (int k = 0; k < 16; k++) chk("t2_rr_order", 32'(qg(bg + k)), 32'((5 + k) % N));
        for (int t = 0; t < N; t++) begin
            cnt = 0;
            for (int k = 0; k < 16; k++) if (qg(bg + k) == t) cnt++;
            chk("t2_grant_count", 32'(cnt), 32'd2);
        end

        // Wraparound on addition.
        tb_ld = 1'b1; ld_a = 5'd7; ld_d = 32'hFFFF_0000; cyc(); tb_ld = 1'b0;
        req_set(1, 32'd7, 32'h0002_0000); wait_idle(10); step(); step();
        chk("t4_wrap", mem[7], 32'h0001_0000);

        // Out-of-range destination.
        req_set(4, 32'd40, 32'd5); step();
        chk("t3_ready4", 32'(last_ready[4]), 32'd1);
        chk("t3_no_rd", 32'(last_rd_en), 32'd0);
        chk("t3_err_next", 32'(dest_err), 32'd1);
        step();
        chk("t3_no_wr", 32'(last_wr_en), 32'd0);
        chk("t3_err_sticky", 32'(dest_err), 32'd1);

        // Finish with one update in flight.
        req_set(2, 32'd5, 32'h0000_1234); step();
        intf.thread_done = '1;
        wait_complete(20);
        chk("t5_err_held", 32'(dest_err), 32'd1);
        repeat (3) cyc();
        chk("t5_done_held", 32'(DMP_operation_complete), 32'd1);
        intf.thread_done = '0;
        pulse_next();
        chk("t5_complete_clr", 32'(DMP_operation_complete), 32'd0);
        chk("t5_err_clr", 32'(dest_err), 32'd0);

        // Randomized iterations.
        for (int it = 0; it < 2; it++) begin
            for (int c = 0; c < 300; c++) begin
                for (int t = 0; t < N; t++) begin
                    if (!intf.req_valid[t] && $urandom_range(0, 2) == 0)
                        req_set(t, ($urandom_range(0, 15) == 0) ? 32'($urandom_range(32, 40))
                                                               : 32'($urandom_range(0, 5)), $urandom);
                    intf.thread_done[t] = ($urandom_range(0, 63) == 0);
                end
                nextIteration = ($urandom_range(0, 49) == 0);
                step();
            end
            nextIteration = 1'b0; intf.req_valid = '0; intf.thread_done = '1;
            wait_complete(40);
            intf.thread_done = '0;
            pulse_next();
        end

        // Reset on the cycle after a grant.
        req_set(3, 32'd9, 32'h55); cyc();
        reset_n = 1'b0; intf.req_valid = '0; #1;
        chk("t6_wr_en", 32'(mem_wr_en), 32'd0);
        chk("t6_wr_addr", 32'(mem_wr_addr), 32'd0);
        chk("t6_wr_data", mem_wr_data, 32'd0);
        chk("t6_rd_en", 32'(mem_rd_en), 32'd0);
        chk("t6_ready", 32'(intf.req_ready), 32'd0);
        cyc(); reset_n = 1'b1; cyc();
        chk("t6_idle_complete", 32'(DMP_operation_complete), 32'd0);
        req_set(0, 32'd1, 32'd1); cyc();
        chk("t6_idle_no_grant", 32'(last_ready), 32'd0);
        intf.req_valid = '0; cyc(); cyc();

        for (int i = 0; i < NODES; i++) chk("final_mem", mem[i], m_acc[i]);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
